// File: rtl/regfile_scoreboard_if.sv
// Bundle between issue/writeback logic (master) and the register file with busy
// scoreboard (slave): writeback, issue, flush, operand read ports and busy count.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic              we;
  logic [AW-1:0]     rd;
  logic [XLEN-1:0]   wd;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              flush;
  logic [NRD*AW-1:0] rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]    rs_busy;
  logic [AW:0]       busy_cnt;

  modport master (
    output we, rd, wd, iss_valid, iss_rd, flush, rs_addr,
    input  rs_data, rs_busy, busy_cnt
  );

  modport slave (
    input  we, rd, wd, iss_valid, iss_rd, flush, rs_addr,
    output rs_data, rs_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file (NRD read ports, one write port, x0 = 0) with a per-register busy
// scoreboard and pending count. Optional same-cycle write bypass: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input logic            clk,
  input logic            rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      cnt_next;
  logic             wr_hit;
  logic             set_hit;
  logic             set_inc;
  logic             clr_dec;

  assign wr_hit  = bus.we && (bus.rd != '0);
  assign set_hit = bus.iss_valid && (bus.iss_rd != '0);

  // Clear is applied before set so a same-register issue/retire pair leaves the register busy.
  // NOTE: every output of this always_comb gets a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr_hit)  busy_next[bus.rd]     = 1'b0;
    if (set_hit) busy_next[bus.iss_rd] = 1'b1;

    set_inc  = set_hit && !busy[bus.iss_rd];
    clr_dec  = wr_hit && busy[bus.rd] && !(set_hit && (bus.iss_rd == bus.rd));
    cnt_next = busy_cnt_q + {{AW{1'b0}}, set_inc} - {{AW{1'b0}}, clr_dec};

    if (bus.flush) begin
      busy_next = '0;
      cnt_next  = '0;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: the register array is architecturally required to reset to zero, so it sits in the
  // async-reset process; this forces flops rather than a RAM macro for the storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      // NOTE: non-blocking assignment for all state so every flop samples pre-edge values.
      regs[bus.rd] <= bus.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_next;
      busy_cnt_q <= cnt_next;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = bus.rs_addr[k*AW +: AW];

    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (addr == bus.rd)) begin
        data = bus.wd;
        bsy  = set_hit && (bus.iss_rd == bus.rd);
      end
`endif
      // Bypassed write data must not leak out while reset is held.
      if ((addr == '0) || rst) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign bus.rs_data[k*XLEN +: XLEN] = data;
    assign bus.rs_busy[k]              = bsy;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios then random traffic,
// compared against an array/popcount reference model. Honours REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREGS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (rst || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.rd != 0 && int'(bus.rd) == a) return bus.wd;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (rst || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.we && bus.rd != 0 && int'(bus.rd) == a)
      return bus.iss_valid && (bus.iss_rd == bus.rd);
`endif
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input int rd, input logic [XLEN-1:0] wd,
                       input logic iv, input int ird, input logic fl,
                       input int a0, input int a1);
    bus.we        = we;
    bus.rd        = AW'(rd);
    bus.wd        = wd;
    bus.iss_valid = iv;
    bus.iss_rd    = AW'(ird);
    bus.flush     = fl;
    bus.rs_addr   = {AW'(a1), AW'(a0)};
  endtask

  // Compare all read ports and the busy count against the model for the current inputs.
  task automatic check_all(input string tag);
    int a;
    #1;
    for (int k = 0; k < NRD; k++) begin
      a = int'(bus.rs_addr[k*AW +: AW]);
      check($sformatf("%s_data%0d_x%0d", tag, k, a), 64'(bus.rs_data[k*XLEN +: XLEN]), 64'(exp_data(a)));
      check($sformatf("%s_busy%0d_x%0d", tag, k, a), 64'(bus.rs_busy[k]), 64'(exp_busy(a)));
    end
    check({tag, "_cnt"}, 64'(bus.busy_cnt), 64'(rst ? 0 : m_count()));
  endtask

  // Advance one clock, applying the spec rules to the model, and return just after negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (bus.we && bus.rd != 0) m_regs[bus.rd] = bus.wd;
      if (bus.flush) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end else begin
        if (bus.we && bus.rd != 0) m_busy[bus.rd] = 1'b0;
        if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic we, input int rd, input logic [XLEN-1:0] wd,
                      input logic iv, input int ird, input logic fl, input int a0, input int a1);
    drive(we, rd, wd, iv, ird, fl, a0, a1);
    check_all(tag);
    tick();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("post_reset");

    // Basic write/read, x0 stays zero.
    step("wr_x3", 1, 3, 32'h1234_5678, 0, 0, 0, 3, 0);
    drive(0, 0, '0, 0, 0, 0, 3, 0);
    #1 check("x3_readback", 64'(bus.rs_data[XLEN-1:0]), 64'h1234_5678);
    step("wr_x0", 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 3);
    drive(0, 0, '0, 0, 0, 0, 0, 3);
    #1 check("x0_zero", 64'(bus.rs_data[XLEN-1:0]), 64'h0);

    // Scoreboard issue and retire.
    step("iss_x7", 0, 0, '0, 1, 7, 0, 7, 9);
    step("iss_x9", 0, 0, '0, 1, 9, 0, 7, 9);
    drive(0, 0, '0, 0, 0, 0, 7, 9);
    #1 check("cnt_two", 64'(bus.busy_cnt), 64'd2);
    check("x7_busy", 64'(bus.rs_busy[0]), 64'd1);
    step("wb_x7", 1, 7, 32'h7777_0000, 0, 0, 0, 7, 9);
    drive(0, 0, '0, 0, 0, 0, 7, 9);
    #1 check("cnt_one", 64'(bus.busy_cnt), 64'd1);
    check("x7_free", 64'(bus.rs_busy[0]), 64'd0);
    check("x9_busy", 64'(bus.rs_busy[1]), 64'd1);

    // Simultaneous set/clear on same and different registers.
    step("iss_x4", 0, 0, '0, 1, 4, 0, 4, 6);
    step("same_x4", 1, 4, 32'h4444_4444, 1, 4, 0, 4, 6);
    drive(0, 0, '0, 0, 0, 0, 4, 6);
    #1 check("same_cnt", 64'(bus.busy_cnt), 64'd2);
    check("same_x4_busy", 64'(bus.rs_busy[0]), 64'd1);
    step("diff", 1, 4, 32'h4444_0004, 1, 6, 0, 4, 6);
    drive(0, 0, '0, 0, 0, 0, 4, 6);
    #1 check("diff_cnt", 64'(bus.busy_cnt), 64'd2);
    check("diff_x4_free", 64'(bus.rs_busy[0]), 64'd0);
    check("diff_x6_busy", 64'(bus.rs_busy[1]), 64'd1);

    // Flush beats a concurrent issue.
    step("iss_x10", 0, 0, '0, 1, 10, 0, 2, 10);
    step("iss_x11", 0, 0, '0, 1, 11, 0, 2, 10);
    step("iss_x12", 0, 0, '0, 1, 12, 0, 2, 10);
    drive(0, 0, '0, 0, 0, 0, 2, 10);
    #1 check("pre_flush_cnt", 64'(bus.busy_cnt), 64'd5);
    step("flush", 0, 0, '0, 1, 2, 1, 2, 10);
    drive(0, 0, '0, 0, 0, 0, 2, 10);
    #1 check("flush_cnt", 64'(bus.busy_cnt), 64'd0);
    check("flush_x2", 64'(bus.rs_busy[0]), 64'd0);

    // Same-cycle write visibility.
    step("wr_x8_old", 1, 8, 32'h1111_1111, 0, 0, 0, 0, 8);
    drive(1, 8, 32'hA5A5_A5A5, 0, 0, 0, 0, 8);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_data", 64'(bus.rs_data[XLEN +: XLEN]), 64'hA5A5_A5A5);
`else
    check("nobypass_data", 64'(bus.rs_data[XLEN +: XLEN]), 64'h1111_1111);
`endif
    check("bypass_busy", 64'(bus.rs_busy[1]), 64'd0);
    tick();

    // Asynchronous reset mid-run.
    step("wr_x5", 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 5);
    step("iss_x5", 0, 0, '0, 1, 5, 0, 5, 5);
    drive(1, 5, 32'hCAFE_F00D, 1, 5, 0, 5, 5);
    #2 rst = 1'b1;
    #1 check("rst_data", 64'(bus.rs_data[XLEN-1:0]), 64'h0);
    check("rst_busy", 64'(bus.rs_busy[0]), 64'd0);
    check("rst_cnt", 64'(bus.busy_cnt), 64'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, '0, 0, 0, 0, 5, 5);
    #1 check("rel_data", 64'(bus.rs_data[XLEN-1:0]), 64'h0);
    check("rel_busy", 64'(bus.rs_busy[0]), 64'd0);
    check("rel_cnt", 64'(bus.busy_cnt), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS-1)), XLEN'($urandom),
           1'($urandom_range(0, 2) != 0), int'($urandom_range(0, NREGS-1)),
           1'($urandom_range(0, 31) == 0),
           int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)));
    end
    drive(0, 0, '0, 0, 0, 0, 1, 2);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
